// File: rtl/pipes_pkg.sv
// Shared pipeline types for the RV64 core front end: fetch buffer entry,
// fetch FSM states and the architectural reset PC.
package pipes_pkg;

   typedef logic [63:0] u64;
   typedef logic [31:0] u32;

   localparam u64 PC_RESET = 64'h0000_0000_8000_0000;

   typedef struct packed {
      u64   pc;
      u32   instr;
      logic exc;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DROP
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between the fetch FSM and decode. Flush has
// priority over push and pop; payload storage is not reset.
module fetch_fifo
   import pipes_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          i_push,
   input  fetch_entry_t  i_entry,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [CW-1:0] o_count,
   output logic          o_valid,
   output fetch_entry_t  o_head
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign w_do_pop  = i_pop & (r_count != '0);
   assign w_do_push = i_push & ((r_count < CW'(DEPTH)) | w_do_pop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + AW'(1);
         if (w_do_pop)  r_rd <= r_rd + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr] <= i_entry;
   end

   assign o_count = r_count;
   assign o_valid = (r_count != '0);
   assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one outstanding bus request at a
// time, buffers responses and handles execute redirects.
module fetch_stage #(
   parameter logic [63:0] PC_RESET   = pipes_pkg::PC_RESET,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_addr_ok,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        if_valid,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_exc,
   input  logic        id_ready
);

   import pipes_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t  r_state;
   fetch_state_t  w_state_nxt;
   logic [63:0]   r_pc;
   logic [63:0]   w_pc_nxt;
   logic          r_halted;
   logic          w_halted_nxt;
   logic          r_redir_pend;
   logic          w_pend_nxt;
   logic [63:0]   r_redir_pc;
   logic [63:0]   w_rpc_nxt;
   logic          w_push;
   fetch_entry_t  w_push_entry;
   logic [CW-1:0] w_count;
   logic          w_space;
   logic          w_aligned;
   logic          w_req;
   logic          w_fire;
   logic          w_head_vld;
   fetch_entry_t  w_head;

   // Space is judged on the registered count only, keeping id_ready off the request path.
   assign w_space   = (w_count < CW'(FIFO_DEPTH));
   assign w_aligned = (r_pc[1:0] == 2'b00);
   assign w_req     = (r_state == S_REQ) & w_space & ~r_halted & w_aligned;
   assign w_fire    = w_req & iresp_addr_ok;

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_halted_nxt = r_halted;
      w_pend_nxt   = r_redir_pend;
      w_rpc_nxt    = r_redir_pc;
      w_push       = 1'b0;
      w_push_entry = '{pc: r_pc, instr: iresp_data, exc: 1'b0};
      if (redirect_valid) w_halted_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
            if (redirect_valid) w_pc_nxt = redirect_pc;
         end
         S_REQ: begin
            if (w_fire) begin
               w_pend_nxt = 1'b0;
               if (iresp_data_ok) begin
                  if (redirect_valid)    w_pc_nxt = redirect_pc;
                  else if (r_redir_pend) w_pc_nxt = r_redir_pc;
                  else begin
                     w_push   = 1'b1;
                     w_pc_nxt = r_pc + 64'd4;
                  end
               end else if (redirect_valid || r_redir_pend) begin
                  w_state_nxt = S_DROP;
                  if (redirect_valid) w_rpc_nxt = redirect_pc;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else if (redirect_valid) begin
               // An asserted request may not be withdrawn: defer the new PC.
               if (w_req) begin
                  w_pend_nxt = 1'b1;
                  w_rpc_nxt  = redirect_pc;
               end else begin
                  w_pc_nxt = redirect_pc;
               end
            end else if (!w_aligned && w_space && !r_halted) begin
               w_push             = 1'b1;
               w_push_entry.instr = '0;
               w_push_entry.exc   = 1'b1;
               w_halted_nxt       = 1'b1;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               if (iresp_data_ok) begin
                  w_pc_nxt    = redirect_pc;
                  w_state_nxt = S_REQ;
               end else begin
                  w_rpc_nxt   = redirect_pc;
                  w_state_nxt = S_DROP;
               end
            end else if (iresp_data_ok) begin
               w_push      = 1'b1;
               w_pc_nxt    = r_pc + 64'd4;
               w_state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect_valid) w_rpc_nxt = redirect_pc;
            if (iresp_data_ok) begin
               w_pc_nxt    = redirect_valid ? redirect_pc : r_redir_pc;
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_pc         <= PC_RESET;
         r_halted     <= 1'b0;
         r_redir_pend <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_halted     <= w_halted_nxt;
         r_redir_pend <= w_pend_nxt;
      end
   end

   always_ff @(posedge clk) begin
      r_redir_pc <= w_rpc_nxt;
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_push),
      .i_entry (w_push_entry),
      .i_pop   (if_valid & id_ready),
      .i_flush (redirect_valid),
      .o_count (w_count),
      .o_valid (w_head_vld),
      .o_head  (w_head)
   );

   assign ireq_valid = w_req;
   assign ireq_addr  = r_pc;
   assign if_valid   = w_head_vld;
   assign if_pc      = w_head_vld ? w_head.pc    : '0;
   assign if_instr   = w_head_vld ? w_head.instr : '0;
   assign if_exc     = w_head_vld & w_head.exc;

endmodule
